// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the multiplier round/pack pipeline
package mul_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RDN = 2'b10,
    RND_RUP = 2'b11
  } rnd_mode_e;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } mul_flags_t;

  // Result class carried from the round stage to the pack stage
  localparam logic [1:0] CLS_FIN  = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set
  function automatic logic [63:0] canon_nan(input int expo_w, input int mant_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < expo_w; i++) v[mant_w + i] = 1'b1;
    v[mant_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mul_round.sv
// rtl/mul_round.sv - rounding increment, carry-out and overflow/underflow select
module mul_round
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic              sign,
  input  logic [EXPO_W+1:0] expo,
  input  logic [MANT_W:0]   mant,
  input  logic              guard,
  input  logic              sticky,
  input  logic [1:0]        rnd,
  output logic [EXPO_W-1:0] expo_f,
  output logic [MANT_W-1:0] frac_f,
  output logic              of,
  output logic              uf,
  output logic              nx
);

  logic              inc;
  logic              to_inf;
  logic              carry;
  logic [MANT_W-1:0] frac_inc;
  logic [EXPO_W+1:0] expo_r;
  logic              ovf;
  logic              unf;

  // Round increment and overflow direction chosen by rounding mode and sign
  always_comb begin
    inc    = 1'b0;
    to_inf = 1'b1;
    case (rnd_mode_e'(rnd))
      RND_RNE: begin inc = guard & (sticky | mant[0]); to_inf = 1'b1;  end
      RND_RTZ: begin inc = 1'b0;                       to_inf = 1'b0;  end
      RND_RDN: begin inc = sign & (guard | sticky);    to_inf = sign;  end
      default: begin inc = ~sign & (guard | sticky);   to_inf = ~sign; end
    endcase
  end

  // A carry out of the full mantissa only happens when every bit is 1; the
  // stored fraction then wraps to 0, which is exactly the 1.0 renormalization.
  assign carry    = inc & (&mant);
  assign frac_inc = mant[MANT_W-1:0] + MANT_W'(inc);
  assign expo_r   = expo + (EXPO_W+2)'(carry);

  // Exponent is signed: negative or zero flushes, all-ones or beyond overflows
  assign ovf = ~expo_r[EXPO_W+1] & (expo_r[EXPO_W:0] >= (EXPO_W+1)'((2**EXPO_W) - 1));
  assign unf = expo_r[EXPO_W+1] | (expo_r == '0);

  // Final exponent/fraction fields and exception flags for a finite operand
  always_comb begin
    of = ovf;
    uf = unf;
    nx = guard | sticky | ovf | unf;
    if (ovf) begin
      expo_f = to_inf ? {EXPO_W{1'b1}} : {{(EXPO_W-1){1'b1}}, 1'b0};
      frac_f = to_inf ? {MANT_W{1'b0}} : {MANT_W{1'b1}};
    end else if (unf) begin
      expo_f = '0;
      frac_f = '0;
    end else begin
      expo_f = expo_r[EXPO_W-1:0];
      frac_f = frac_inc;
    end
  end

endmodule

// File: rtl/mul_pack_pipe.sv
// rtl/mul_pack_pipe.sv - two-stage round/pack pipeline with valid/ready handshake
module mul_pack_pipe
  import mul_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             r_sign,
  input  logic [EXPO_W+1:0]                r_expo,
  input  logic [MANT_W:0]                  r_mant,
  input  logic                             r_guard,
  input  logic                             r_sticky,
  input  logic [1:0]                       rnd,
  input  logic                             r_isnan,
  input  logic                             is_inf_nan,
  input  logic                             r_is0nan,
  input  logic                             status_nv,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  result,
  output logic                             flag_nv,
  output logic                             flag_of,
  output logic                             flag_uf,
  output logic                             flag_nx
);

  localparam int RES_W = SIGN_W + EXPO_W + MANT_W;
  localparam logic [RES_W-1:0] QNAN = RES_W'(canon_nan(EXPO_W, MANT_W));

  logic              s1_valid, s2_valid, s1_adv, accept;
  logic              s1_sign;
  logic [1:0]        s1_cls;
  logic [EXPO_W-1:0] s1_expo;
  logic [MANT_W-1:0] s1_frac;
  mul_flags_t        s1_flags;
  mul_flags_t        s2_flags;
  logic [RES_W-1:0]  pack;

  logic [EXPO_W-1:0] rd_expo;
  logic [MANT_W-1:0] rd_frac;
  logic              rd_of, rd_uf, rd_nx;
  logic [1:0]        in_cls;
  mul_flags_t        in_flags;

  // S1 moves on whenever S2 is free or being drained; reset blocks intake
  assign s1_adv    = ~s2_valid | out_ready;
  assign in_ready  = ~rst & (~s1_valid | s1_adv);
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  mul_round #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_round (
    .sign   (r_sign),
    .expo   (r_expo),
    .mant   (r_mant),
    .guard  (r_guard),
    .sticky (r_sticky),
    .rnd    (rnd),
    .expo_f (rd_expo),
    .frac_f (rd_frac),
    .of     (rd_of),
    .uf     (rd_uf),
    .nx     (rd_nx)
  );

  // Special-case class by priority, and flags that only finite results raise
  always_comb begin
    if (r_isnan)         in_cls = CLS_NAN;
    else if (is_inf_nan) in_cls = CLS_INF;
    else if (r_is0nan)   in_cls = CLS_ZERO;
    else                 in_cls = CLS_FIN;
    in_flags.nv = status_nv;
    in_flags.of = (in_cls == CLS_FIN) & rd_of;
    in_flags.uf = (in_cls == CLS_FIN) & rd_uf;
    in_flags.nx = (in_cls == CLS_FIN) & rd_nx;
  end

  // S1: capture the rounded fields when a transaction is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_FIN;
      s1_expo  <= '0;
      s1_frac  <= '0;
      s1_flags <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_sign  <= r_sign;
        s1_cls   <= in_cls;
        s1_expo  <= rd_expo;
        s1_frac  <= rd_frac;
        s1_flags <= in_flags;
      end
    end
  end

  // Pack the S1 fields into the IEEE word according to class
  always_comb begin
    case (s1_cls)
      CLS_NAN:  pack = QNAN;
      CLS_INF:  pack = {SIGN_W'(s1_sign), {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      CLS_ZERO: pack = {SIGN_W'(s1_sign), {EXPO_W{1'b0}}, {MANT_W{1'b0}}};
      default:  pack = {SIGN_W'(s1_sign), s1_expo, s1_frac};
    endcase
  end

  // S2: output register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= '0;
      s2_flags <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result   <= pack;
        s2_flags <= s1_flags;
      end
    end
  end

  assign flag_nv = s2_flags.nv;
  assign flag_of = s2_flags.of;
  assign flag_uf = s2_flags.uf;
  assign flag_nx = s2_flags.nx;

endmodule
